q_8_40_mult_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared byte-serial 32×32 multiplier (`q_8_40`). It takes 32-bit operand pairs from two clients, grants the multiplier round-robin, and streams the operands onto the 8-bit `M` bus with a `start` pulse. It then collects the eight product bytes from `P` while `send_output` is high and returns a 64-bit product to the granted client with a one-cycle done pulse. A watchdog aborts a transaction if the multiplier never answers.

---
 rtl/q_8_40_mult_arb.sv | 190 +++++++++++++++++++
 tb/tb_q_8_40_mult_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/q_8_40_mult_arb.sv
// Round-robin arbiter and byte-serial sequencer for the shared q_8_40 multiplier.
// Streams {b, a} onto M, collects eight product bytes from P, and aborts via watchdog.
module q_8_40_mult_arb #(
   parameter logic [5:0] WD_MAX = 6'd63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [63:0] prod,
   output logic        busy,
   input  logic        mult_rdy,
   output logic        mult_start,
   output logic [7:0]  mult_m,
   input  logic        mult_send,
   input  logic [7:0]  mult_p
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      WAIT    = 3'd2,
      COLLECT = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic [2:0]  cnt_r, cnt_s;
   logic [5:0]  wd_r, wd_s;
   logic        last_r, last_s;
   logic        gnt_r, gnt_s;
   logic        err_r, err_s;
   logic [31:0] a_r, a_s;
   logic [31:0] b_r, b_s;
   logic [63:0] pbuf_r, pbuf_s;
   logic [63:0] prod_r;
   logic        done0_r, done1_r, err0_r, err1_r, busy_r;

   function automatic logic [7:0] byte_sel(input logic [63:0] w, input logic [2:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

   // Next-state and datapath update for the transaction sequencer.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      wd_s    = wd_r;
      last_s  = last_r;
      gnt_s   = gnt_r;
      err_s   = err_r;
      a_s     = a_r;
      b_s     = b_r;
      pbuf_s  = pbuf_r;
      case (state_r)
         IDLE: begin
            if ((req0 || req1) && mult_rdy) begin
               // On a tie the client not served last wins.
               if (req0 && req1) begin
                  gnt_s = ~last_r;
               end else begin
                  gnt_s = req1;
               end
               a_s     = gnt_s ? a1 : a0;
               b_s     = gnt_s ? b1 : b0;
               cnt_s   = 3'd0;
               err_s   = 1'b0;
               pbuf_s  = 64'd0;
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
               wd_s    = 6'd0;
               state_s = WAIT;
            end else begin
               state_s = LOAD;
            end
         end
         WAIT: begin
            if (mult_send) begin
               pbuf_s[7:0] = mult_p;
               cnt_s       = 3'd1;
               state_s     = COLLECT;
            end else begin
               wd_s = wd_r + 6'd1;
               if (wd_r == WD_MAX) begin
                  err_s   = 1'b1;
                  state_s = DONE;
               end else begin
                  state_s = WAIT;
               end
            end
         end
         COLLECT: begin
            if (mult_send) begin
               pbuf_s[{cnt_r, 3'b000} +: 8] = mult_p;
               cnt_s = cnt_r + 3'd1;
               if (cnt_r == 3'd7) begin
                  state_s = DONE;
               end else begin
                  state_s = COLLECT;
               end
            end else begin
               state_s = COLLECT;
            end
         end
         DONE: begin
            last_s  = gnt_r;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered client-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= 3'd0;
         wd_r    <= 6'd0;
         last_r  <= 1'b1;
         gnt_r   <= 1'b0;
         err_r   <= 1'b0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         pbuf_r  <= 64'd0;
         prod_r  <= 64'd0;
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         err0_r  <= 1'b0;
         err1_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         wd_r    <= wd_s;
         last_r  <= last_s;
         gnt_r   <= gnt_s;
         err_r   <= err_s;
         a_r     <= a_s;
         b_r     <= b_s;
         pbuf_r  <= pbuf_s;
         // Pulses and prod are loaded on entry to DONE so they are valid during it.
         done0_r <= (state_s == DONE) && !err_s && !gnt_s;
         done1_r <= (state_s == DONE) && !err_s && gnt_s;
         err0_r  <= (state_s == DONE) && err_s && !gnt_s;
         err1_r  <= (state_s == DONE) && err_s && gnt_s;
         busy_r  <= (state_s != IDLE);
         if (state_s == DONE) begin
            prod_r <= err_s ? 64'd0 : pbuf_s;
         end else begin
            prod_r <= prod_r;
         end
      end
   end

   // Operand bus and start strobe, decoded from registers only.
   always_comb begin
      mult_start = 1'b0;
      mult_m     = 8'd0;
      if (state_r == LOAD) begin
         mult_start = (cnt_r == 3'd0);
         mult_m     = byte_sel({b_r, a_r}, cnt_r);
      end else begin
         mult_start = 1'b0;
         mult_m     = 8'd0;
      end
   end

   assign done0 = done0_r;
   assign done1 = done1_r;
   assign err0  = err0_r;
   assign err1  = err1_r;
   assign prod  = prod_r;
   assign busy  = busy_r;

endmodule

// File: tb/tb_q_8_40_mult_arb.sv
// Directed bench for q_8_40_mult_arb with an in-bench byte-serial multiplier stub.
module tb_q_8_40_mult_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [31:0] a0, b0, a1, b1;
   logic        done0, done1, err0, err1;
   logic [63:0] prod;
   logic        busy;
   logic        mult_rdy;
   logic        mult_start;
   logic [7:0]  mult_m;
   logic        mult_send;
   logic [7:0]  mult_p;

   int checks = 0;
   int errors = 0;

   q_8_40_mult_arb dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .prod(prod), .busy(busy),
      .mult_rdy(mult_rdy), .mult_start(mult_start), .mult_m(mult_m),
      .mult_send(mult_send), .mult_p(mult_p)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction from the start strobe to the IDLE cycle after DONE.
   // The stub multiplies the operands it actually received on M.
   task automatic serve(input string tag, input logic [63:0] exp_ops, input int lat,
                        input int stall_at, input int stall_len, input bit never,
                        input int exp_cyc, input logic [3:0] exp_flags,
                        input logic [63:0] exp_prod, input bit keep);
      logic [63:0] ops;
      logic [63:0] pval;
      int n;
      int cyc;
      n = 0;
      while (mult_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start"}, {63'd0, mult_start}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         ops[i*8 +: 8] = mult_m;
         if (i < 7) @(negedge clk);
      end
      chk({tag, "_ops"}, ops, exp_ops);
      pval = {32'd0, ops[31:0]} * {32'd0, ops[63:32]};
      @(negedge clk);
      cyc = 8;
      if (!never) begin
         repeat (lat) begin
            @(negedge clk);
            cyc++;
         end
         for (int j = 0; j < 8; j++) begin
            mult_send = 1'b1;
            mult_p    = pval[j*8 +: 8];
            @(negedge clk);
            cyc++;
            if (j == stall_at) begin
               mult_send = 1'b0;
               repeat (stall_len) begin
                  @(negedge clk);
                  cyc++;
               end
            end
         end
         mult_send = 1'b0;
         mult_p    = 8'd0;
      end
      n = 0;
      while (!(done0 || done1 || err0 || err1) && n < 120) begin
         @(negedge clk);
         cyc++;
         n++;
      end
      chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_flags"}, {60'd0, err1, err0, done1, done0}, {60'd0, exp_flags});
      chk({tag, "_prod"}, prod, exp_prod);
      chk({tag, "_m_idle"}, {56'd0, mult_m}, 64'd0);
      if (!keep) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      logic [3:0] seen;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
      mult_rdy = 1'b1; mult_send = 1'b0; mult_p = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_prod", prod, 64'd0);
      chk("rst_outs", {58'd0, busy, mult_start, done0, done1, err0, err1}, 64'd0);
      chk("rst_m", {56'd0, mult_m}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single request from client 0.
      a0 = 32'h0000_00AA; b0 = 32'h0000_0003; req0 = 1'b1;
      serve("single0", 64'h0000_0003_0000_00AA, 0, -1, 0, 1'b0, 16, 4'b0001,
            64'h0000_0000_0000_01FE, 1'b0);

      // Maximum operands from client 1, two-cycle multiplier latency.
      a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; req1 = 1'b1;
      serve("max1", 64'hFFFF_FFFF_FFFF_FFFF, 2, -1, 0, 1'b0, 18, 4'b0010,
            64'hFFFF_FFFE_0000_0001, 1'b0);

      // Both requests held: strict alternation starting with client 0.
      a0 = 32'd2; b0 = 32'd3; a1 = 32'd5; b1 = 32'd7;
      req0 = 1'b1; req1 = 1'b1;
      serve("rr_a", 64'h0000_0003_0000_0002, 0, -1, 0, 1'b0, 16, 4'b0001, 64'd6, 1'b1);
      serve("rr_b", 64'h0000_0007_0000_0005, 0, -1, 0, 1'b0, 16, 4'b0010, 64'd35, 1'b1);
      serve("rr_c", 64'h0000_0003_0000_0002, 0, -1, 0, 1'b0, 16, 4'b0001, 64'd6, 1'b0);

      // Multiplier not ready: stay idle until mult_rdy rises.
      mult_rdy = 1'b0;
      a0 = 32'h0000_1234; b0 = 32'h0000_0010; req0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rdy_low_busy", {62'd0, busy, mult_start}, 64'd0);
      end
      mult_rdy = 1'b1;
      @(negedge clk);
      chk("rdy_high_start", {63'd0, mult_start}, 64'd1);
      serve("rdy", 64'h0000_0010_0000_1234, 0, -1, 0, 1'b0, 16, 4'b0001,
            64'h0000_0000_0001_2340, 1'b0);

      // Watchdog abort, then a normal transaction.
      a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
      serve("wdog", 64'h0000_0009_0000_0009, 0, -1, 0, 1'b1, 72, 4'b0100, 64'd0, 1'b0);
      req0 = 1'b1;
      serve("after_wd", 64'h0000_0009_0000_0009, 1, -1, 0, 1'b0, 17, 4'b0001,
            64'h0000_0000_0000_0051, 1'b0);

      // Three-cycle stall in COLLECT after byte 2.
      a1 = 32'h0000_0100; b1 = 32'h0000_0100; req1 = 1'b1;
      serve("stall", 64'h0000_0100_0000_0100, 1, 2, 3, 1'b0, 20, 4'b0010,
            64'h0000_0000_0001_0000, 1'b0);

      // Reset during LOAD with cnt = 4.
      a0 = 32'h1111_1111; b0 = 32'h2222_22C5; req0 = 1'b1;
      begin
         int n;
         n = 0;
         while (mult_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      chk("rstmid_start", {63'd0, mult_start}, 64'd1);
      repeat (4) @(negedge clk);
      chk("rstmid_byte4", {56'd0, mult_m}, 64'h0000_0000_0000_00C5);
      rst = 1'b1;
      req0 = 1'b0;
      #1;
      chk("rstmid_outs", {62'd0, busy, mult_start}, 64'd0);
      chk("rstmid_m", {56'd0, mult_m}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 4'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen = seen | {err1, err0, done1, done0};
      end
      chk("rstmid_no_done", {60'd0, seen}, 64'd0);
      chk("rstmid_prod", prod, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
